logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-bit 2-input gate: WIDTH-bit bitwise

---
 rtl/logic_unit_if.sv | 30 +++
 rtl/logic_unit_pipe.sv | 97 +++++++++
 tb/tb_logic_unit_pipe.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_if.sv
// Request/response bundle for the pipelined logic unit.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds its payload stable while valid=1 and ready=0, and ready may
// depend combinationally on the downstream ready (never on the payload).
interface logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;

  // Request source / result consumer side.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones
  );

  // The logic unit itself.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with run-time op select behind an elastic
// LATENCY-stage valid/ready pipeline. Zero/all-ones flags are computed once
// at capture and travel alongside the data.
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input logic         clk,
  input logic         rst,
  logic_unit_if.slave bus
);

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] ld;
  logic [LATENCY-1:0] zf;
  logic [LATENCY-1:0] of;
  logic [WIDTH-1:0]   dat [LATENCY];

  logic [LATENCY-1:0] src_v;
  logic [LATENCY-1:0] src_z;
  logic [LATENCY-1:0] src_o;
  logic [WIDTH-1:0]   src_d [LATENCY];
  logic [WIDTH-1:0]   res;

  // Bitwise result of the request currently on the input side.
  always_comb begin
    res = '0;
    case (bus.op)
      3'd0:    res = bus.a & bus.b;
      3'd1:    res = ~(bus.a & bus.b);
      3'd2:    res = bus.a | bus.b;
      3'd3:    res = ~(bus.a | bus.b);
      3'd4:    res = bus.a ^ bus.b;
      3'd5:    res = ~(bus.a ^ bus.b);
      3'd6:    res = ~bus.a;
      default: res = bus.a;
    endcase
  end

  // A stage may load when the consumer is taking data or any stage at or
  // after it is empty; this lets bubbles collapse under a stall.
  always_comb begin
    ld = '0;
    for (int k = 0; k < LATENCY; k++) begin
      ld[k] = bus.out_ready;
      for (int j = k; j < LATENCY; j++) begin
        if (!vld[j]) ld[k] = 1'b1;
      end
    end
  end

  // What each stage would capture: the new request for stage 0, the previous
  // stage's contents otherwise.
  always_comb begin
    src_v    = '0;
    src_z    = '0;
    src_o    = '0;
    src_v[0] = bus.in_valid;
    src_d[0] = res;
    src_z[0] = (res == '0);
    src_o[0] = (res == '1);
    for (int k = 1; k < LATENCY; k++) begin
      src_v[k] = vld[k-1];
      src_d[k] = dat[k-1];
      src_z[k] = zf[k-1];
      src_o[k] = of[k-1];
    end
  end

  // Pipeline registers; payload only updates when a valid item moves in.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      zf  <= '0;
      of  <= '0;
      for (int k = 0; k < LATENCY; k++) dat[k] <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        if (ld[k]) begin
          vld[k] <= src_v[k];
          if (src_v[k]) begin
            dat[k] <= src_d[k];
            zf[k]  <= src_z[k];
            of[k]  <= src_o[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld[LATENCY-1];
  assign bus.y         = dat[LATENCY-1];
  assign bus.y_zero    = zf[LATENCY-1];
  assign bus.y_ones    = of[LATENCY-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: an 8-bit/2-stage instance checked every cycle
// against a queue-based transaction model, plus a 1-bit/1-stage instance
// exercised with the NAND truth table.
module tb_logic_unit_pipe;
  localparam int W = 8;
  localparam int L = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic_unit_if #(.WIDTH(W)) bus ();
  logic_unit_if #(.WIDTH(1)) bus1 ();

  logic_unit_pipe #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic_unit_pipe #(.WIDTH(1), .LATENCY(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_y[$];
  logic         got_z[$];
  logic         got_o[$];
  int           got_cyc[$];
  int           acc_cyc[$];
  bit           armed = 1'b0;
  bit           saw_block = 1'b0;
  bit           stalled_prev = 1'b0;
  logic [W-1:0] y_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic clear_log();
    got_y.delete();
    got_z.delete();
    got_o.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  // ---------------- scoreboard / compare process ----------------
  // Mid-cycle: inputs change only just after a rising edge, so what is seen
  // here is what the next edge will act on.
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", bus.in_ready, ((exp_q.size() < L) || bus.out_ready) ? 1 : 0);
      if (!bus.in_ready) saw_block = 1'b1;
      if (stalled_prev) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_y", bus.y, y_prev);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_without_item", bus.out_valid, 0);
        end else begin
          check("y", bus.y, exp_q[0]);
          check("y_zero", bus.y_zero, (exp_q[0] == '0) ? 1 : 0);
          check("y_ones", bus.y_ones, (exp_q[0] == '1) ? 1 : 0);
        end
      end
      stalled_prev = bus.out_valid && !bus.out_ready && !rst;
      y_prev       = bus.y;
      if (rst) begin
        exp_q.delete();
        stalled_prev = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          got_y.push_back(bus.y);
          got_z.push_back(bus.y_zero);
          got_o.push_back(bus.y_ones);
          got_cyc.push_back(cyc);
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.op));
          acc_cyc.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d items pending, expected 0", exp_q.size());
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] exp2 [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
  logic [7:0] exp4 [5] = '{8'hC0, 8'hFC, 8'h3C, 8'h0F, 8'hF0};
  logic [2:0] ops4 [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
  logic       exp6 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bus.in_valid   = 1'b1;
    bus.a          = 8'hF0;
    bus.b          = 8'hCC;
    bus.op         = 3'd0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = 1'b0;
    bus1.b         = 1'b0;
    bus1.op        = 3'd1;
    bus1.out_ready = 1'b1;

    // Reset held two cycles with a request offered.
    @(posedge clk);
    #1;
    armed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_y", bus.y, 0);
      check("rst_y_zero", bus.y_zero, 0);
      check("rst_y_ones", bus.y_ones, 0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Truth sweep, back-to-back.
    clear_log();
    for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i));
    bus.in_valid = 1'b0;
    wait_drain();
    check("sweep_count", got_y.size(), 8);
    if (got_y.size() == 8 && acc_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("sweep_y%0d", i), got_y[i], exp2[i]);
        check($sformatf("sweep_cycle%0d", i), got_cyc[i], acc_cyc[0] + 1 + i);
      end
    end

    // Flags.
    clear_log();
    send(8'hFF, 8'hFF, 3'd1);
    send(8'hFF, 8'hFF, 3'd0);
    bus.in_valid = 1'b0;
    wait_drain();
    check("flags_count", got_y.size(), 2);
    if (got_y.size() == 2) begin
      check("flags_nand_y", got_y[0], 8'h00);
      check("flags_nand_zero", got_z[0], 1);
      check("flags_nand_ones", got_o[0], 0);
      check("flags_and_y", got_y[1], 8'hFF);
      check("flags_and_zero", got_z[1], 0);
      check("flags_and_ones", got_o[1], 1);
    end

    // Backpressure: consumer stalls for 4 cycles during a 5-item stream.
    clear_log();
    saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(8'hF0, 8'hCC, ops4[i]);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_blocked", saw_block, 1);
    check("bp_count", got_y.size(), 5);
    if (got_y.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("bp_y%0d", i), got_y[i], exp4[i]);
    end

    // Random-ish burst with a jittery consumer.
    clear_log();
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        bus.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("burst_count", got_y.size(), 20);

    // Reset with two items in flight.
    clear_log();
    bus.out_ready = 1'b0;
    send(8'hF0, 8'hCC, 3'd0);
    send(8'hF0, 8'hCC, 3'd2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_dropped", got_y.size(), 0);

    // 1-bit, 1-stage NAND table.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab            = 2'(i);
      bus1.a        = ab[1];
      bus1.b        = ab[0];
      bus1.op       = 3'd1;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("w1_in_ready%0d", i), bus1.in_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("w1_valid%0d", i), bus1.out_valid, 1);
      check($sformatf("w1_y%0d", i), bus1.y, exp6[i]);
      check($sformatf("w1_zero%0d", i), bus1.y_zero, exp6[i] ? 0 : 1);
      check($sformatf("w1_ones%0d", i), bus1.y_ones, exp6[i] ? 1 : 0);
    end
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w1_idle_valid", bus1.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
